// File: rtl/toy_pack.sv
// Shared payload type for instructions flowing from dispatch to the FP unit.
package toy_pack;

   typedef struct packed {
      logic [5:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rs3;
      logic [5:0] tag;
   } forward_pkg;

endpackage

// File: rtl/toy_float_issue_queue.sv
// In-order FP issue queue: circular buffer feeding a single-cycle issue pulse
// to an external FP unit, with in-flight tracking until the commit strobe.
module toy_float_issue_queue
   import toy_pack::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enq_vld,
   output logic                     enq_rdy,
   input  forward_pkg               enq_pld,
   input  logic                     flush,
   output logic                     fp_vld,
   input  logic                     fp_rdy,
   output forward_pkg               fp_pld,
   input  logic                     fp_done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     idle
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   forward_pkg          mem_q [DEPTH];
   logic [PW-1:0]       head_q, head_d;
   logic [PW-1:0]       tail_q, tail_d;
   logic [CW-1:0]       count_q, count_d;
   logic                fp_vld_q, fp_vld_d;
   forward_pkg          fp_pld_q, fp_pld_d;
   logic                inflight_q, inflight_d;
   logic                enq_fire;
   logic                fire;

   // enq_rdy looks only at occupancy, so a full queue refuses even when it pops.
   assign enq_rdy  = (count_q < CW'(DEPTH)) & ~flush;
   assign enq_fire = enq_vld & enq_rdy;
   assign fire     = (count_q != '0) & fp_rdy & ~fp_vld_q & ~flush;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      fp_vld_d   = fire;
      fp_pld_d   = fp_pld_q;
      inflight_d = fp_vld_q | (inflight_q & ~fp_done);
      if (flush) begin
         count_d = '0;
         head_d  = tail_q;
      end else begin
         if (enq_fire) tail_d = tail_q + PW'(1);
         if (fire) begin
            head_d   = head_q + PW'(1);
            fp_pld_d = mem_q[head_q];
         end
         case ({enq_fire, fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         fp_vld_q   <= 1'b0;
         fp_pld_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         fp_vld_q   <= fp_vld_d;
         fp_pld_q   <= fp_pld_d;
         inflight_q <= inflight_d;
      end
   end

   // Entry storage carries no reset; validity lives entirely in the pointers.
   always_ff @(posedge clk) begin
      if (enq_fire & ~rst) mem_q[tail_q] <= enq_pld;
   end

   assign fp_vld = fp_vld_q;
   assign fp_pld = fp_pld_q;
   assign count  = count_q;
   assign idle   = (count_q == '0) & ~fp_vld_q & ~inflight_q;

endmodule

// File: doc/toy_float_issue_queue.md
TOY_FLOAT_ISSUE_QUEUE -- requirements
Module: toy_float_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entry count (power of two, >=2).
REQ-002 SHALL have ports clk  in  1  clock; all logic on posedge, one clock domain.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port enq_vld  in  1  dispatch offers one FP instruction.
REQ-005 SHALL have port enq_rdy  out  1  queue accepts; transfer on enq_vld & enq_rdy.
REQ-006 SHALL have port enq_pld  in  forward_pkg  instruction payload.
REQ-007 SHALL have port flush  in  1  pipeline kill; discard all queued entries.
REQ-008 SHALL have port fp_vld  out  1  single-cycle issue pulse to FP unit.
REQ-009 SHALL have port fp_rdy  in  1  FP unit idle; combinationally depends on fp_vld.
REQ-010 SHALL have port fp_pld  out  forward_pkg  issued instruction, valid while fp_vld.
REQ-011 SHALL have port fp_done  in  1  FP unit commit strobe (inst_commit_en).
REQ-012 SHALL have port count  out  $clog2(DEPTH)+1  occupancy.
REQ-013 SHALL have port idle  out  1  queue empty, no pulse pending, nothing in flight.

Function
REQ-014 SHALL keep entries in a circular buffer with head/tail pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0; issue strictly in enqueue order.
REQ-015 SHALL drive enq_rdy = (count < DEPTH) & ~flush, independent of same-cycle issue; no enqueue while full, even if a pop occurs that cycle.
REQ-016 SHALL fire in cycle t when count != 0 & fp_rdy & ~fp_vld & ~flush; fire pops head at the t edge.
REQ-017 SHALL drive fp_vld and fp_pld from flops: cycle t+1 fp_vld=1, fp_pld=popped entry; fp_vld high exactly one cycle per fire.
REQ-018 SHALL never use fp_vld combinationally to compute fp_vld (no loop through fp_rdy).
REQ-019 SHALL hold fp_pld at last issued value when fp_vld=0.
REQ-020 SHALL support simultaneous enqueue and fire: count unchanged, tail and head both advance.
REQ-021 SHALL, on flush: set count=0, head=tail, no enqueue, no fire that cycle; an fp_vld pulse already on the wire that cycle completes unchanged.
REQ-022 SHALL set inflight on fp_vld, clear it on fp_done; fp_done and new fp_vld same cycle leave inflight=1; flush does not clear inflight.
REQ-023 SHALL drive idle = (count==0) & ~fp_vld & ~inflight.
REQ-024 SHALL increment/decrement count with no overflow/underflow.

Reset
REQ-025 SHALL, with rst high at a clock edge, set count=0, head=tail=0, fp_vld=0, fp_pld=0, inflight=0; hence enq_rdy=1, idle=1 after reset.
REQ-026 SHALL take reset priority over flush, enqueue and fire; mid-operation reset drops queued entries and any pending pulse.
REQ-027 SHALL not reset entry storage (data don't-care when invalid).

Structure
REQ-028 SHALL import forward_pkg from toy_pack; DEPTH stays a local parameter; no new package types.
REQ-029 SHALL be a single module, no sub-modules; the FP unit is external.

Verification
REQ-030 SHALL cover: reset, then enqueue A with fp_rdy=1 at cycle 0 -> enq at 0, fire at 1, fp_vld=1, fp_pld=A at 2 only, count 1->0.
REQ-031 SHALL cover: enqueue A,B,C,D back-to-back with fp_rdy=0 -> count=4, enq_rdy=0, fifth offer refused; fp_rdy=1 -> A,B,C,D issued in order, one pulse per idle window.
REQ-032 SHALL cover: count=4 with enq_vld and fire same cycle -> no enqueue, count=3; count=2 with enq and fire -> count stays 2, pointers wrap 3->0 correctly.
REQ-033 SHALL cover: flush with count=3 and fp_vld=1 -> that pulse still seen, count=0 next cycle, no further fp_vld, inflight cleared only by fp_done.
REQ-034 SHALL cover: rst asserted with count=2 and fire pending -> next cycle fp_vld=0, count=0, idle=1.
REQ-035 SHALL cover: fp_done coincident with a new fp_vld -> inflight stays 1, idle=0 until next fp_done.
